// File: rtl/stat_graph.sv
// stat_graph: population-history bar graph overlay.
//
// Counts live cells per generation, samples the closing count every SAMPLE_PERIOD
// generations into a WIDTH-entry circular history, and renders that history as a
// bar graph inside the window at (GRAPH_ORIGIN_X, GRAPH_ORIGIN_Y). The render path
// has a fixed 2-cycle latency. The syncs and blank pass through the same 2-cycle delay.
//
// Optional build macro STAT_GRAPH_AXIS_EN: when it is defined, the window draws the
// left column and the bottom row in AXIS_COLOR.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   cell_valid_in             a cell result is presented this cycle
//   cell_alive_in             that cell is alive (qualified by cell_valid_in)
//   gen_done_in               single-cycle end-of-generation pulse
//   hcount_in, vcount_in      VGA raster position
//   hsync_in, vsync_in        VGA syncs
//   blank_in                  VGA blank
//   pixel_out                 graph colour, 0 = transparent
//   hsync_out, vsync_out      syncs delayed 2 cycles
//   blank_out                 blank delayed 2 cycles
module stat_graph #(
  parameter int unsigned SAMPLE_PERIOD  = 2,
  parameter int unsigned WIDTH          = 128,
  parameter int unsigned HEIGHT         = 128,
  parameter int unsigned SCALE_SHIFT    = 11,
  parameter int unsigned GRAPH_ORIGIN_X = 16,
  parameter int unsigned GRAPH_ORIGIN_Y = 16,
  parameter int unsigned HCOUNT_WIDTH   = 11,
  parameter int unsigned VCOUNT_WIDTH   = 10,
`ifdef STAT_GRAPH_AXIS_EN
  parameter logic [11:0] AXIS_COLOR     = 12'hFFF,
`endif
  parameter logic [11:0] GRAPH_COLOR    = 12'hF80
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    cell_valid_in,
  input  logic                    cell_alive_in,
  input  logic                    gen_done_in,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    blank_in,
  output logic [11:0]             pixel_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    blank_out
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned CW = XW + 1;
  localparam int unsigned PW = 18;

  typedef logic [HCOUNT_WIDTH:0] hx_t;
  typedef logic [VCOUNT_WIDTH:0] vy_t;
  typedef logic [HCOUNT_WIDTH-1:0] hc_t;
  typedef logic [VCOUNT_WIDTH-1:0] vc_t;
  typedef logic [XW-1:0] x_t;
  typedef logic [YW-1:0] y_t;
  typedef logic [CW-1:0] c_t;
  typedef logic [PW-1:0] p_t;

  localparam p_t  POP_MAX  = '1;
  localparam logic [7:0] GEN_LAST = 8'(SAMPLE_PERIOD - 1);
  localparam c_t  CNT_FULL = c_t'(WIDTH);
  localparam y_t  Y_TOP    = y_t'(HEIGHT - 1);
  localparam p_t  H_CLAMP  = p_t'(HEIGHT - 1);
  localparam hx_t X_LO     = hx_t'(GRAPH_ORIGIN_X);
  localparam hx_t X_HI     = hx_t'(GRAPH_ORIGIN_X + WIDTH);
  localparam vy_t Y_LO     = vy_t'(GRAPH_ORIGIN_Y);
  localparam vy_t Y_HI     = vy_t'(GRAPH_ORIGIN_Y + HEIGHT);

  // ---------------------------------------------------------------------------
  // Population counting and sampling
  // ---------------------------------------------------------------------------
  p_t         pop_cnt_q, pop_cnt_d, closing, scaled;
  logic [7:0] gen_cnt_q, gen_cnt_d;
  x_t         wr_ptr_q;
  c_t         sample_cnt_q;
  y_t         h_new;
  logic       cell_hit, sample_now;

  always_comb begin
    cell_hit = cell_valid_in & cell_alive_in;
    // A cell arriving with gen_done_in still belongs to the closing generation.
    closing  = pop_cnt_q;
    if (cell_hit && (pop_cnt_q != POP_MAX)) closing = pop_cnt_q + 1'b1;
    pop_cnt_d  = gen_done_in ? '0 : closing;
    sample_now = gen_done_in && (gen_cnt_q == GEN_LAST);
    gen_cnt_d  = gen_cnt_q;
    if (gen_done_in) gen_cnt_d = sample_now ? '0 : gen_cnt_q + 1'b1;
    scaled = closing >> SCALE_SHIFT;
    h_new  = (scaled > H_CLAMP) ? Y_TOP : scaled[YW-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pop_cnt_q    <= '0;
      gen_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      sample_cnt_q <= '0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
      gen_cnt_q <= gen_cnt_d;
      if (sample_now) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (sample_cnt_q != CNT_FULL) sample_cnt_q <= sample_cnt_q + 1'b1;
      end
    end
  end

  // History RAM. It has no reset: sample_cnt_q masks the columns that were never written.
  y_t hist [WIDTH];

  always_ff @(posedge clk_in) begin
    if (sample_now) hist[wr_ptr_q] <= h_new;
  end

  // ---------------------------------------------------------------------------
  // Render stage 1: window decode and synchronous history read
  // ---------------------------------------------------------------------------
  logic in_win;
  x_t   x_s1, rd_idx;
  y_t   y_s1;

  always_comb begin
    in_win = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
             ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    x_s1   = x_t'(hcount_in - hc_t'(GRAPH_ORIGIN_X));
    y_s1   = y_t'(vcount_in - vc_t'(GRAPH_ORIGIN_Y));
    // Once the history is full, the oldest entry sits at wr_ptr and is drawn leftmost.
    rd_idx = (sample_cnt_q == CNT_FULL) ? x_t'(wr_ptr_q + x_s1) : x_s1;
  end

  y_t rd_h_q;

  always_ff @(posedge clk_in) begin
    rd_h_q <= hist[rd_idx];
  end

  logic win_q, hsync_q, vsync_q, blank_q;
  x_t   x_q;
  y_t   y_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      win_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      win_q   <= in_win;
      x_q     <= x_s1;
      y_q     <= y_s1;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
      blank_q <= blank_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Render stage 2: bar compare and output register
  // ---------------------------------------------------------------------------
  logic        col_valid, lit;
  logic [11:0] pixel_d;

  always_comb begin
    col_valid = {1'b0, x_q} < sample_cnt_q;
    // The bar grows upward from the bottom row, so h = 0 lights only that row.
    lit       = win_q && col_valid && ((Y_TOP - y_q) <= rd_h_q);
    pixel_d   = lit ? GRAPH_COLOR : 12'h000;
`ifdef STAT_GRAPH_AXIS_EN
    if (win_q && ((x_q == '0) || (y_q == Y_TOP))) pixel_d = AXIS_COLOR;
`endif
    if (blank_q) pixel_d = 12'h000;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      pixel_out <= pixel_d;
      hsync_out <= hsync_q;
      vsync_out <= vsync_q;
      blank_out <= blank_q;
    end
  end

endmodule

// File: tb/tb_stat_graph.sv
// Directed bench for stat_graph. dut_a uses the default parameters. dut_b uses
// SCALE_SHIFT=0 and SAMPLE_PERIOD=1, so that clamping and history wrap need only
// a few cells each.
module tb_stat_graph;

  localparam int OX = 16;
  localparam int OY = 16;
  localparam logic [11:0] BAR = 12'hF80;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, aa, gda, vb, ab, gdb;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        hs, vs, bl;
  logic [11:0] pix_a, pix_b;
  logic        hso_a, vso_a, blo_a, hso_b, vso_b, blo_b;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  stat_graph dut_a (
    .clk_in(clk), .rst_in(rst), .cell_valid_in(va), .cell_alive_in(aa), .gen_done_in(gda),
    .hcount_in(hc), .vcount_in(vc), .hsync_in(hs), .vsync_in(vs), .blank_in(bl),
    .pixel_out(pix_a), .hsync_out(hso_a), .vsync_out(vso_a), .blank_out(blo_a)
  );

  stat_graph #(.SAMPLE_PERIOD(1), .SCALE_SHIFT(0)) dut_b (
    .clk_in(clk), .rst_in(rst), .cell_valid_in(vb), .cell_alive_in(ab), .gen_done_in(gdb),
    .hcount_in(hc), .vcount_in(vc), .hsync_in(hs), .vsync_in(vs), .blank_in(bl),
    .pixel_out(pix_b), .hsync_out(hso_b), .vsync_out(vso_b), .blank_out(blo_b)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed %h expected %h", tag, obs, exp);
  endtask

  // Expected pixel for window coordinate (x,y), given the bar colour expected there.
  function automatic logic [11:0] want(input int x, input int y, input logic blk,
                                       input logic [11:0] bar);
    if (blk) return 12'h000;
`ifdef STAT_GRAPH_AXIS_EN
    if (x >= 0 && x < 128 && y >= 0 && y < 128 && (x == 0 || y == 127)) return 12'hFFF;
`endif
    return bar;
  endfunction

  task automatic probe(input int x, input int y, input logic blk);
    @(negedge clk);
    hc = 11'(OX + x); vc = 10'(OY + y); bl = blk; hs = 1'b0; vs = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pa(input string tag, input int x, input int y, input logic blk,
                    input logic [11:0] bar);
    probe(x, y, blk);
    chk(tag, pix_a, want(x, y, blk, bar));
  endtask

  task automatic pb(input string tag, input int x, input int y, input logic blk,
                    input logic [11:0] bar);
    probe(x, y, blk);
    chk(tag, pix_b, want(x, y, blk, bar));
  endtask

  task automatic cells_a(input int n, input logic valid, input logic alive);
    repeat (n) begin @(negedge clk); va = valid; aa = alive; end
    @(negedge clk); va = 1'b0; aa = 1'b0;
  endtask

  task automatic done_a(input logic with_cell);
    @(negedge clk); gda = 1'b1; va = with_cell; aa = with_cell;
    @(negedge clk); gda = 1'b0; va = 1'b0; aa = 1'b0;
  endtask

  task automatic cells_b(input int n);
    repeat (n) begin @(negedge clk); vb = 1'b1; ab = 1'b1; end
    @(negedge clk); vb = 1'b0; ab = 1'b0;
  endtask

  task automatic done_b();
    @(negedge clk); gdb = 1'b1;
    @(negedge clk); gdb = 1'b0;
  endtask

  // Streams the window plus a 2-pixel border one pixel per cycle and checks each output
  // against the inputs that were driven two cycles earlier. The history is empty here.
  task automatic scan();
    logic [11:0] p1, p2;
    logic h1, h2, v1, v2, b1, b2;
    int n = 0;
    p1 = '0; p2 = '0; h1 = 0; h2 = 0; v1 = 0; v2 = 0; b1 = 0; b2 = 0;
    for (int v = OY - 2; v < OY + 130; v++) begin
      for (int h = OX - 2; h < OX + 130; h++) begin
        @(negedge clk);
        if (n >= 2) begin
          chk("scan_pix_a", pix_a, p2);
          chk("scan_pix_b", pix_b, p2);
          chk("scan_hsync", {11'd0, hso_a}, {11'd0, h2});
          chk("scan_vsync", {11'd0, vso_a}, {11'd0, v2});
          chk("scan_blank", {11'd0, blo_a}, {11'd0, b2});
        end
        p2 = p1; h2 = h1; v2 = v1; b2 = b1;
        hc = 11'(h); vc = 10'(v);
        hs = (h % 7) == 0; vs = (v % 5) == 0; bl = (h % 11) == 3;
        p1 = want(h - OX, v - OY, bl, 12'h000); h1 = hs; v1 = vs; b1 = bl;
        n++;
      end
    end
    repeat (2) begin
      @(negedge clk);
      chk("scan_pix_tail", pix_a, p2);
      chk("scan_hsync_tail", {11'd0, hso_a}, {11'd0, h2});
      p2 = p1; h2 = h1;
    end
  endtask

  initial begin
    rst = 1'b1;
    va = 0; aa = 0; gda = 0; vb = 0; ab = 0; gdb = 0;
    hc = 11'(OX); vc = 10'(OY + 127); hs = 1; vs = 1; bl = 1;
    repeat (3) @(negedge clk);
    chk("rst_pix_a", pix_a, 12'h000);
    chk("rst_pix_b", pix_b, 12'h000);
    chk("rst_hsync", {11'd0, hso_a}, 12'h000);
    chk("rst_vsync", {11'd0, vso_a}, 12'h000);
    chk("rst_blank", {11'd0, blo_a}, 12'h000);
    rst = 1'b0;

    scan();

    // Two generations of 4096 and 6144 cells: only the second is sampled, 6144>>11 = 3.
    cells_a(4096, 1, 1); done_a(0);
    cells_a(6144, 1, 1); done_a(0);
    pa("h3_y127", 0, 127, 0, BAR);
    pa("h3_y125", 0, 125, 0, BAR);
    pa("h3_y124", 0, 124, 0, BAR);
    pa("h3_y123", 0, 123, 0, 12'h000);
    pa("h3_blank", 0, 127, 1, BAR);
    pa("h3_col1_empty", 1, 127, 0, 12'h000);
    pa("h3_left_of_win", -1, 127, 0, 12'h000);
    pa("h3_below_win", 0, 128, 0, 12'h000);

    // Unsampled generation, then 2047 cells plus one on the gen_done cycle: 2048 -> h=1.
    done_a(0);
    cells_a(2047, 1, 1); done_a(1);
    pa("same_cycle_y126", 1, 126, 0, BAR);
    pa("same_cycle_y125", 1, 125, 0, 12'h000);

    // Next sampled generation: 2047 counted cells plus unqualified cycles -> h=0.
    done_a(0);
    cells_a(50, 0, 1); cells_a(50, 1, 0); cells_a(2047, 1, 1); done_a(0);
    pa("h0_y127", 2, 127, 0, BAR);
    pa("h0_y126", 2, 126, 0, 12'h000);

    // Wrap: 130 samples with h = i mod 128.
    for (int i = 0; i < 130; i++) begin
      cells_b(i % 128);
      done_b();
    end
    pb("wrap_c0_y125", 0, 125, 0, BAR);
    pb("wrap_c0_y124", 0, 124, 0, 12'h000);
    pb("wrap_c1_y124", 1, 124, 0, BAR);
    pb("wrap_c1_y123", 1, 123, 0, 12'h000);
    pb("wrap_c127_y126", 127, 126, 0, BAR);
    pb("wrap_c127_y125", 127, 125, 0, 12'h000);

    // A population of 200 clamps to h=127 and lights the full newest column.
    cells_b(200); done_b();
    pb("sat_c127_y0", 127, 0, 0, BAR);
    pb("sat_c127_y64", 127, 64, 0, BAR);
    pb("sat_c126_y126", 126, 126, 0, BAR);
    pb("sat_c126_y125", 126, 125, 0, 12'h000);
    pb("sat_c0_y124", 0, 124, 0, BAR);
    pb("sat_c0_y123", 0, 123, 0, 12'h000);

    // Reset in mid-frame: the outputs clear without waiting for a clock edge.
    probe(0, 127, 0);
    hs = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_pix", pix_a, want(0, 127, 0, BAR));
    chk("pre_rst_hsync", {11'd0, hso_a}, 12'h001);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_pix_a", pix_a, 12'h000);
    chk("midrst_pix_b", pix_b, 12'h000);
    chk("midrst_hsync", {11'd0, hso_a}, 12'h000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    pa("post_rst_empty_a", 0, 127, 0, 12'h000);
    pb("post_rst_empty_b", 127, 0, 0, 12'h000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/stat_graph.md
Name: stat_graph

Overview:
- Population-history graph stage, downstream of the cell-update engine and upstream of the pixel mixer.
- Counts live cells in each generation and samples the count every GRAPH_SAMPLE_PERIOD generations.
- Stores the samples in a GRAPH_WIDTH-entry circular history.
- Renders the history as a bar graph in the window at GRAPH_ORIGIN_X/GRAPH_ORIGIN_Y, driven from the VGA hcount/vcount stream.

Parameters:
- SAMPLE_PERIOD, GRAPH_SAMPLE_PERIOD (2), generations per stored sample; legal range 1..255.
- WIDTH, GRAPH_WIDTH (128), history depth and window width in pixels; power of two.
- HEIGHT, GRAPH_HEIGHT (128), window height in pixels; power of two.
- SCALE_SHIFT, 11, right shift applied to the population before plotting.
- GRAPH_COLOR, 12'hF80, colour of bar pixels.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-high
- cell_valid_in  input  1  one cell result is presented this cycle
- cell_alive_in  input  1  that cell is alive; qualified by cell_valid_in
- gen_done_in  input  1  single-cycle pulse marking the end of a generation
- hcount_in  input  HCOUNT_WIDTH  VGA horizontal count
- vcount_in  input  VCOUNT_WIDTH  VGA vertical count
- hsync_in  input  1  VGA hsync
- vsync_in  input  1  VGA vsync
- blank_in  input  1  VGA blank
- pixel_out  output  12  graph pixel colour; 0 means transparent
- hsync_out  output  1  hsync delayed 2 cycles
- vsync_out  output  1  vsync delayed 2 cycles
- blank_out  output  1  blank delayed 2 cycles

Behaviour:
- Reset (asynchronous), all cleared to 0:
  - pop_cnt (18 bits), gen_cnt, wr_ptr, sample_cnt
  - all delay registers
  - pixel_out, hsync_out, vsync_out, blank_out
  - history RAM contents are don't-care; sample_cnt masks unwritten columns.
- Population count:
  - pop_cnt increments when cell_valid_in && cell_alive_in.
  - Saturates at 2^18-1 and never wraps.
- Generation end (gen_done_in high):
  - closing = pop_cnt + (cell_valid_in && cell_alive_in), saturated. A cell arriving on the same cycle as gen_done_in belongs to the closing generation.
  - pop_cnt <= 0.
  - If gen_cnt == SAMPLE_PERIOD-1: gen_cnt <= 0 and the sample is stored. Otherwise gen_cnt increments.
- Sample store:
  - h = min(closing >> SCALE_SHIFT, HEIGHT-1), 7 bits.
  - hist[wr_ptr] <= h; wr_ptr <= (wr_ptr+1) mod WIDTH.
  - sample_cnt increments, saturating at WIDTH.
  - The newly stored value is visible to rendering from the next cycle.
- Render pipeline, fixed latency of 2 cycles:
  - Stage 1:
    - in_win = hcount in [GRAPH_ORIGIN_X, GRAPH_ORIGIN_X+WIDTH) and vcount in [GRAPH_ORIGIN_Y, GRAPH_ORIGIN_Y+HEIGHT).
    - x = hcount-GRAPH_ORIGIN_X; y = vcount-GRAPH_ORIGIN_Y.
    - Read index: (wr_ptr+x) mod WIDTH when sample_cnt==WIDTH, else x. Oldest sample is at the left.
    - RAM read is synchronous (BRAM).
  - Stage 2:
    - col_valid = x < sample_cnt.
    - lit = in_win && col_valid && (HEIGHT-1-y) <= h_read.
    - pixel_out = (lit && !blank) ? GRAPH_COLOR : 0.
  - The syncs and blank are delayed 2 cycles to stay aligned with pixel_out.
- Boundaries:
  - Pixels outside the window are always 0.
  - A sample with h=0 lights only the bottom row of its column.
  - A write during the visible frame may tear by one column; accepted.
  - After wrap, the column for the newest sample is x=WIDTH-1.
- Reset mid-frame: outputs go to 0 immediately; the history is empty on release.

Optional Feature:
- Macro: STAT_GRAPH_AXIS_EN.
- Defined:
  - Window pixels with x==0 or y==HEIGHT-1 output AXIS_COLOR (12'hFFF), overriding bar colour and col_valid.
  - Adds parameter AXIS_COLOR.
- Undefined: no axis is drawn; the AXIS_COLOR parameter is absent.
- Latency is 2 cycles in both builds.

Test Plan:
- Reset, then scan a full frame -> pixel_out 0 everywhere; syncs and blank match the inputs delayed by exactly 2 cycles.
- 4096 alive cells, gen_done, second gen with 6144 alive, gen_done (period 2) -> one sample h=3 stored at column 0; pixel lit at vcount=GRAPH_ORIGIN_Y+124..127, dark at +123.
- Population 2^18-1 in the sampled generation -> h saturates at 127; the whole column x=0 is lit.
- Alive cell on the same cycle as gen_done -> counted in the closing generation: 2047 prior alive plus 1 gives h=1; the next generation starts at 0.
- 130 samples with h equal to the sample index mod 128 -> wrap; column 0 shows the sample with index 2 (h=2); column 127 shows index 129 (h=1).
- Build with STAT_GRAPH_AXIS_EN and empty history -> column x=0 and row y=127 are 12'hFFF; the rest of the window is 0.
